// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Posted-write FIFO between store alignment and the data-memory
//                bus. Stores are enqueued from the MEM stage and drained to
//                memory with a req/gnt handshake. Loads that overlap a pending
//                store are flagged so the hazard unit can stall them.
//
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                st_valid/st_ready   - store enqueue handshake
//                st_addr/wdata/be    - store address, lane-aligned data, lanes
//                mem_req/mem_gnt     - head-entry write handshake to memory
//                mem_addr/wdata/be   - head entry (word aligned, 0 when empty)
//                ld_addr/ld_be       - load in MEM stage to check for overlap
//                ld_hazard           - load overlaps a pending store
//                ld_fwd_valid/data   - store-to-load forwarding result
//                empty/full          - occupancy status
//
//  Option      : STORE_BUF_FWD_EN - when defined, matching entries forward
//                their data per byte lane (youngest wins); a fully covered load
//                reports ld_fwd_valid and no hazard. When undefined the
//                forwarding outputs are tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_wdata,
    input  logic [3:0]      st_be,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [3:0]      ld_be,
    output logic            ld_hazard,
    output logic            ld_fwd_valid,
    output logic [XLEN-1:0] ld_fwd_data,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

    // Entry storage; contents are never reset because validity comes from
    // the pointers and count alone.
    logic [XLEN-3:0] r_addr [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [3:0]      r_be   [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_hit;
    logic             w_hazard_raw;

    // Address byte-offset bits play no role in word matching or in the bus
    // address; they are collected here only so they are visibly consumed.
    logic w_unused_bits;
    assign w_unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_cnt);
    // No full-bypass: a pop in the same cycle does not free a slot for a push.
    assign w_push  = st_valid && !w_full;
    // A grant with nothing pending is ignored.
    assign w_pop   = mem_gnt && !w_empty;

    assign st_ready = !w_full;
    assign empty    = w_empty;
    assign full     = w_full;
    assign mem_req  = !w_empty;

    // Head outputs are masked while empty so unreset storage never leaks out.
    assign mem_addr  = w_empty ? '0 : {r_addr[r_rd_ptr], 2'b00};
    assign mem_wdata = w_empty ? '0 : r_data[r_rd_ptr];
    assign mem_be    = w_empty ? '0 : r_be[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr[XLEN-1:2];
            r_data[r_wr_ptr] <= st_wdata;
            r_be[r_wr_ptr]   <= st_be;
        end
    end

    // An entry is live when its distance from the head is below the count.
    // The head being popped this cycle is still live for hazard purposes.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [PTR_W-1:0] w_age;
            assign w_age      = PTR_W'(i) - r_rd_ptr;
            assign w_valid[i] = ({1'b0, w_age} < r_count);
            assign w_match[i] = w_valid[i] && (r_addr[i] == ld_addr[XLEN-1:2]);
            assign w_hit[i]   = w_match[i] && ((r_be[i] & ld_be) != 4'b0000);
        end
    endgenerate

    assign w_hazard_raw = |w_hit;

`ifdef STORE_BUF_FWD_EN
    logic [XLEN-1:0]  w_fwd_data;
    logic [3:0]       w_cov;
    logic [PTR_W-1:0] w_idx;

    // Walk entries oldest to youngest so later writes overwrite earlier ones
    // lane by lane. Only lanes the load reads are returned.
    always_comb begin
        w_fwd_data = '0;
        w_cov      = 4'b0000;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PTR_W'(k);
            if (w_match[w_idx]) begin
                w_cov = w_cov | r_be[w_idx];
                for (int b = 0; b < 4; b++) begin
                    if (r_be[w_idx][b] && ld_be[b]) begin
                        w_fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    // A load reading no lanes has nothing to forward.
    assign ld_fwd_valid = (ld_be != 4'b0000) && ((ld_be & ~w_cov) == 4'b0000);
    assign ld_fwd_data  = w_fwd_data;
    assign ld_hazard    = w_hazard_raw && !ld_fwd_valid;
`else
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = '0;
    assign ld_hazard    = w_hazard_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Randomized and directed bench for store_buffer with a
//                queue-based reference model and a drain scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        ld_hazard;
    logic        ld_fwd_valid;
    logic [31:0] ld_fwd_data;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    ent_t mdl[$];    // reference contents of the buffer, oldest first
    ent_t exp_q[$];  // expected memory writes, in order

    store_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
        .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hazard(ld_hazard), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: expected combinational view -------------
    logic        m_hz;
    logic        m_fv;
    logic [31:0] m_fd;
    logic [3:0]  m_cov;

    task automatic model_load(output logic hz, output logic fv, output logic [31:0] fd);
        logic [31:0] merged;
        logic [3:0]  cov;
        logic        raw;
        merged = 32'h0;
        cov    = 4'h0;
        raw    = 1'b0;
        foreach (mdl[k]) begin
            if (mdl[k].addr[31:2] == ld_addr[31:2]) begin
                if ((mdl[k].be & ld_be) != 4'h0) raw = 1'b1;
                cov = cov | mdl[k].be;
                for (int b = 0; b < 4; b++)
                    if (mdl[k].be[b]) merged[8*b +: 8] = mdl[k].data[8*b +: 8];
            end
        end
`ifdef STORE_BUF_FWD_EN
        fv = (ld_be != 4'h0) && ((ld_be & ~cov) == 4'h0);
        fd = 32'h0;
        for (int b = 0; b < 4; b++)
            if (ld_be[b] && cov[b]) fd[8*b +: 8] = merged[8*b +: 8];
        hz = raw && !fv;
`else
        fv = 1'b0;
        fd = 32'h0;
        hz = raw;
`endif
    endtask

    // Model: compare status and load outputs, then advance model state.
    always @(negedge clk) begin
        int sz;
        sz = mdl.size();
        model_load(m_hz, m_fv, m_fd);
        chk("mem_req",   {63'b0, mem_req},   {63'b0, sz != 0});
        chk("empty",     {63'b0, empty},     {63'b0, sz == 0});
        chk("full",      {63'b0, full},      {63'b0, sz == DEPTH});
        chk("st_ready",  {63'b0, st_ready},  {63'b0, sz != DEPTH});
        chk("ld_hazard", {63'b0, ld_hazard}, {63'b0, m_hz});
        chk("fwd_valid", {63'b0, ld_fwd_valid}, {63'b0, m_fv});
        chk("fwd_data",  {32'b0, ld_fwd_data},  {32'b0, m_fd});
        if (sz == 0)
            chk("idle_bus", {28'b0, mem_addr, mem_be}, 64'h0);
        if (rst) begin
            mdl.delete();
            exp_q.delete();
        end else begin
            if (mem_gnt && sz > 0) void'(mdl.pop_front());
            if (st_valid && sz < DEPTH) begin
                ent_t e;
                e.addr = st_addr;
                e.data = st_wdata;
                e.be   = st_be;
                mdl.push_back(e);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: every granted write must be the next expected one.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL drain_unexpected: got addr %0h expected no write", mem_addr);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("drain_addr", {32'b0, mem_addr},  {32'b0, e.addr[31:2], 2'b00});
                chk("drain_data", {32'b0, mem_wdata}, {32'b0, e.data});
                chk("drain_be",   {60'b0, mem_be},    {60'b0, e.be});
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_be    = be;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        mem_gnt = 1'b1;
        n = 0;
        while (mem_req && n < 20) begin
            tick();
            n++;
        end
        chk("drain_done", {63'b0, empty}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = 0; st_wdata = 0; st_be = 0;
        mem_gnt = 1'b0; ld_addr = 0; ld_be = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_empty",    {63'b0, empty},    64'h1);
        chk("rst_full",     {63'b0, full},     64'h0);
        chk("rst_req",      {63'b0, mem_req},  64'h0);
        chk("rst_ready",    {63'b0, st_ready}, 64'h1);

        // Single store, latency one, drained on the next grant.
        mem_gnt = 1'b1;
        push(32'h100, 32'h0000_00AB, 4'b0001);
        chk("lat_req",  {63'b0, mem_req}, 64'h1);
        chk("lat_addr", {32'b0, mem_addr}, 64'h100);
        chk("lat_be",   {60'b0, mem_be},   64'h1);
        tick();
        chk("lat_empty", {63'b0, empty}, 64'h1);

        // Fill, refuse a fifth, pop-only when full, then refill.
        mem_gnt = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(32'h110 + 4*i, 32'hA0 + i, 4'hF);
        chk("fill_full",  {63'b0, full},     64'h1);
        chk("fill_ready", {63'b0, st_ready}, 64'h0);
        st_valid = 1'b1; st_addr = 32'h150; st_wdata = 32'h55; st_be = 4'h3;
        tick();
        chk("fifth_blocked", {63'b0, full}, 64'h1);
        mem_gnt = 1'b1;
        tick();
        chk("pop_only_full", {63'b0, full}, 64'h0);
        mem_gnt = 1'b0;
        tick();
        st_valid = 1'b0;
        chk("refill_full", {63'b0, full}, 64'h1);
        drain();

        // Overlap detection.
        mem_gnt = 1'b0;
        push(32'h204, 32'hDEAD_0000, 4'b1100);
        ld_addr = 32'h206; ld_be = 4'b0100; #1;
`ifdef STORE_BUF_FWD_EN
        chk("hz_lane2", {63'b0, ld_hazard}, 64'h0);
        chk("fw_lane2", {63'b0, ld_fwd_valid}, 64'h1);
`else
        chk("hz_lane2", {63'b0, ld_hazard}, 64'h1);
`endif
        ld_be = 4'b0011; #1;
        chk("hz_disjoint", {63'b0, ld_hazard}, 64'h0);
        ld_addr = 32'h208; ld_be = 4'b0100; #1;
        chk("hz_other_word", {63'b0, ld_hazard}, 64'h0);

        // Younger partial store over an older full-word store.
        push(32'h300, 32'h1122_3344, 4'b1111);
        push(32'h300, 32'h0000_00AA, 4'b0001);
        ld_addr = 32'h300; ld_be = 4'b0011; #1;
`ifdef STORE_BUF_FWD_EN
        chk("fwd_valid_merge", {63'b0, ld_fwd_valid}, 64'h1);
        chk("fwd_data_merge",  {32'b0, ld_fwd_data},  64'h0000_33AA);
        chk("fwd_no_hazard",   {63'b0, ld_hazard},    64'h0);
`else
        chk("nofwd_valid",  {63'b0, ld_fwd_valid}, 64'h0);
        chk("nofwd_hazard", {63'b0, ld_hazard},    64'h1);
`endif

        // Reset with three pending entries discards them.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req",   {63'b0, mem_req},   64'h0);
        chk("mid_rst_empty", {63'b0, empty},     64'h1);
        chk("mid_rst_ready", {63'b0, st_ready},  64'h1);
        chk("mid_rst_hz",    {63'b0, ld_hazard}, 64'h0);
        mem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale", {63'b0, mem_req}, 64'h0);
        end

        // Random traffic on a narrow address window to provoke overlaps.
        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            st_valid = $urandom_range(0, 1);
            st_addr  = 32'h400 + 4*$urandom_range(0, 5) + $urandom_range(0, 3);
            st_wdata = $urandom;
            st_be    = 4'($urandom_range(0, 15));
            mem_gnt  = ($urandom_range(0, 2) != 0);
            ld_addr  = 32'h400 + 4*$urandom_range(0, 5) + $urandom_range(0, 3);
            ld_be    = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        st_valid = 1'b0;
        drain();
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the store alignment logic and the data-memory bus.
- Accepts aligned store data plus byte enables from the MEM stage and drains entries to memory with a req/gnt handshake. The pipeline does not stall on memory latency.
- Flags loads that overlap pending stores so the hazard unit can stall them.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, >= 2
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  XLEN  store byte address
- st_wdata  in  XLEN  lane-aligned store data
- st_be  in  4  byte enables; 4'b0000 is legal and is enqueued
- mem_req  out  1  head entry valid, write request to memory
- mem_gnt  in  1  memory accepts head this cycle
- mem_addr  out  XLEN  head address, with [1:0] forced to 2'b00
- mem_wdata  out  XLEN  head data
- mem_be  out  4  head byte enables
- ld_addr  in  XLEN  address of the load in MEM stage
- ld_be  in  4  byte lanes the load reads
- ld_hazard  out  1  load overlaps a pending store
- ld_fwd_valid  out  1  forwarding hit (feature only)
- ld_fwd_data  out  XLEN  forwarded word (feature only)
- empty  out  1  no pending stores, used by fence/flush
- full  out  1  DEPTH entries pending

Behaviour:
- Storage: circular array of {addr[XLEN-1:2], data, be}; wr_ptr and rd_ptr are PTR_W bits; count is PTR_W+1 bits.
- Push: occurs when st_valid && st_ready. Entry is written at wr_ptr, wr_ptr increments and wraps modulo DEPTH.
- st_ready = !full. Registered count makes this combinational, with no dependence on mem_gnt.
- Pop: occurs when mem_req && mem_gnt. rd_ptr increments and wraps.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- Full: push is blocked, even if a pop happens that cycle (no full-bypass).
- Empty: mem_req = 0. A store pushed at cycle N appears on mem_req at N+1 (minimum latency 1; no bypass).
- mem_req = !empty. mem_addr, mem_wdata and mem_be come from the head entry and stay stable while mem_req=1 && mem_gnt=0.
- mem_gnt while mem_req=0 is ignored.
- ld_hazard is combinational. It is 1 iff some valid entry has addr[XLEN-1:2] == ld_addr[XLEN-1:2] and (be & ld_be) != 0.
- An entry being popped in the current cycle still counts toward ld_hazard.
- Reset, applied at any time including mid-drain: the cycle after rst is sampled high, pointers and count = 0, empty=1, full=0, mem_req=0, st_ready=1, ld_hazard=0, ld_fwd_valid=0, ld_fwd_data=0, mem_addr/mem_wdata/mem_be=0. Pending stores are discarded.
- Memory side tolerates mem_req dropping on reset without a gnt.
- Outputs show no X after reset. Entry contents need no reset, but outputs are masked to 0 when empty.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined: each word-matching entry contributes its data per lane, youngest-wins per byte (age ordered from rd_ptr).
  - ld_fwd_valid=1 iff every lane in ld_be is covered by some matching entry's be; ld_fwd_data is the merged word, with uncovered lanes 0.
  - When ld_fwd_valid=1, ld_hazard is forced to 0.
- Not defined: ld_fwd_valid and ld_fwd_data are tied to 0, and ld_hazard behaves as above.

Test Plan:
- Reset, then st_valid with addr=0x100, wdata=0x000000AB, be=0001, mem_gnt=1 → mem_req=1 next cycle with mem_addr=0x100, mem_be=0001; empty=1 after the gnt cycle.
- Push 4 stores with mem_gnt=0 → full=1, st_ready=0; fifth st_valid is not accepted. Then one cycle with mem_gnt=1 → full drops and entries drain in push order.
- Full buffer, mem_gnt=1 and st_valid=1 in the same cycle → pop only, count becomes 3. Push accepted next cycle; pointer wrap is verified after 2×DEPTH pushes.
- Pending store addr=0x204, be=1100; load ld_addr=0x206, ld_be=0100 → ld_hazard=1. Same with ld_be=0011 → ld_hazard=0. Load at 0x208 → ld_hazard=0.
- STORE_BUF_FWD_EN: stores 0x300/be=1111/0x11223344, then 0x300/be=0001/0x000000AA; load ld_be=0011 → ld_fwd_valid=1, ld_fwd_data=0x000033AA, ld_hazard=0.
- rst asserted with 3 entries pending and mem_gnt=0 → next cycle mem_req=0, empty=1, st_ready=1; no stale entry issues after rst deasserts.
